// File: rtl/mult_share_sched_pkg.sv
// mult_sched_pkg: shared types and sizing helpers for the multiplier-sharing scheduler
package mult_sched_pkg;
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    function automatic int id_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mult_share_sched_if.sv
// mult_share_sched_if: requester and response handshake bundle of the scheduler
interface mult_share_sched_if
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 4
);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic resp_valid;
    logic resp_ready;
    logic [2*WIDTH-1:0] resp_data;
    logic [id_w(NUM_REQ)-1:0] resp_id;
    modport master(
        output req_valid, req_a, req_b, resp_ready,
        input req_ready, resp_valid, resp_data, resp_id
    );
    modport slave(
        input req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/mult_share_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter, lowest index at or after ptr wins
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]        req,
    input  logic [id_w(N)-1:0]  ptr,
    output logic [N-1:0]        gnt,
    output logic [id_w(N)-1:0]  gnt_idx
);
    localparam int IW = id_w(N);
    // upper copy stays unmasked so the search wraps past N-1 back to 0
    logic [2*N-1:0] masked;
    logic found;
    assign masked = {req, req} & ({2*N{1'b1}} << ptr);
    always_comb begin
        gnt_idx = '0;
        found = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            if (masked[i] && !found) begin
                found = 1'b1;
                gnt_idx = IW'(i % N);
            end
        end
        gnt = found ? N'(1) << gnt_idx : '0;
    end
endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin sharing of one combinational multiplier among NUM_REQ requesters
module mult_share_sched
    import mult_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_sched_if.slave    bus,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p
);
    localparam int IW = id_w(NUM_REQ);
    state_t state;
    logic [IW-1:0] ptr, id_q, gnt_idx;
    logic [NUM_REQ-1:0] gnt;
    logic accept;
    rr_arbiter #(.N(NUM_REQ)) u_arb (.req(bus.req_valid), .ptr(ptr), .gnt(gnt), .gnt_idx(gnt_idx));
    // ready is withheld during reset so nothing is accepted on a reset edge
    assign bus.req_ready = (state == IDLE && !rst) ? gnt : '0;
    assign accept = |(bus.req_valid & bus.req_ready);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            id_q <= '0;
            mul_a <= '0;
            mul_b <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data <= '0;
            bus.resp_id <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    mul_a <= bus.req_a[gnt_idx*WIDTH +: WIDTH];
                    mul_b <= bus.req_b[gnt_idx*WIDTH +: WIDTH];
                    id_q <= gnt_idx;
                    ptr <= gnt_idx == IW'(NUM_REQ-1) ? '0 : gnt_idx + 1'b1;
                    state <= CALC;
                end
                CALC: begin
                    bus.resp_data <= mul_p;
                    bus.resp_id <= id_q;
                    bus.resp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (bus.resp_ready) begin
                    bus.resp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
